// File: rtl/io_periph_responder.sv
`default_nettype none
// io_periph_responder: CPU IO-bus peripheral (0xC0xxxxxx) with LED register, cycle timer, FIFO-fed 8N1 UART TX.
// Revision 1.0
module io_periph_responder #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int LED_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      IO_A,
  input  logic [1:0]       IOReadS,
  input  logic             IOWriteS,
  input  logic [31:0]      IO_write,
  output logic [31:0]      IO_dout,
  output logic             uart_tx,
  output logic [LED_W-1:0] leds
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic       sel, rd, wr;
  logic [1:0] reg_sel;
  logic       unused_addr;

  assign sel         = (IO_A[31:24] == 8'hC0);
  assign reg_sel     = IO_A[3:2];
  assign rd          = sel && (IOReadS != 2'b00);
  assign wr          = sel && IOWriteS;
  assign unused_addr = ^{IO_A[23:4], IO_A[1:0]};

  logic [31:0] timer;
  logic        ovf;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      leds  <= '0;
      timer <= '0;
    end else begin
      if (wr && reg_sel == 2'd0) leds <= IO_write[LED_W-1:0];
      if (wr && reg_sel == 2'd3) timer <= IO_write;
      else                       timer <= timer + 32'd1;
    end
  end

  // TX byte FIFO; full/empty come from pre-edge count so a push while full is dropped.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = wr && (reg_sel == 2'd1) && !full;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= IO_write[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (wr && reg_sel == 2'd1 && full)              ovf <= 1'b1;
      else if (wr && reg_sel == 2'd2 && IO_write[2])  ovf <= 1'b0;
    end
  end

  state_t        state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next, busy;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      uart_tx <= tx_next;
    end
  end

  // The line level is derived from the current state and registered, so the wire lags the FSM by one cycle.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            bit_next   = '0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = !empty || (state != IDLE);

  always_comb begin
    IO_dout = '0;
    if (rd) begin
      case (reg_sel)
        2'd0:    IO_dout = 32'(leds);
        2'd2:    IO_dout = {29'd0, ovf, full, busy};
        2'd3:    IO_dout = timer;
        default: IO_dout = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_periph_responder.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for io_periph_responder: directed scenarios plus randomized register traffic and UART
// byte streams, checked against a behavioural model and an independent serial receiver.
module tb_io_periph_responder;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_LED   = 32'hC000_0000;
  localparam logic [31:0] A_DATA  = 32'hC000_0004;
  localparam logic [31:0] A_STAT  = 32'hC000_0008;
  localparam logic [31:0] A_TIMER = 32'hC000_000C;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IO_A = '0;
  logic [1:0]  IOReadS = '0;
  logic        IOWriteS = 1'b0;
  logic [31:0] IO_write = '0;
  logic [31:0] IO_dout;
  logic        uart_tx;
  logic [7:0]  leds;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] cyc = '0;
  int          rst_count = 0;
  logic [7:0]  rx_q[$];
  int          frame_err = 0;
  logic [7:0]  mon_byte;
  int          mon_rst;

  logic [31:0] m_timer_base, m_timer_cyc;
  logic [7:0]  m_leds;

  io_periph_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .LED_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .IO_A(IO_A), .IOReadS(IOReadS), .IOWriteS(IOWriteS),
    .IO_write(IO_write), .IO_dout(IO_dout), .uart_tx(uart_tx), .leds(leds)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 32'd1;
  always @(posedge CLK) if (RESET) rst_count <= rst_count + 1;

  // Serial receiver: samples the middle of each bit; frames interrupted by reset are discarded.
  initial begin : uart_monitor
    forever begin
      @(posedge CLK); #1;
      if (!RESET && uart_tx === 1'b0) begin
        mon_rst = rst_count;
        repeat (CPB / 2) begin @(posedge CLK); #1; end
        if (uart_tx !== 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) begin @(posedge CLK); #1; end
          mon_byte[k] = uart_tx;
        end
        repeat (CPB) begin @(posedge CLK); #1; end
        if (uart_tx !== 1'b1) frame_err++;
        if (mon_rst == rst_count) rx_q.push_back(mon_byte);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    IO_A = a; IO_write = d; IOWriteS = 1'b1;
    @(posedge CLK); #1;
    IOWriteS = 1'b0; IO_A = '0; IO_write = '0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    IO_A = a; IOReadS = 2'($urandom_range(1, 3));
    #1;
    d = IO_dout;
    IOReadS = 2'b00; IO_A = '0;
  endtask

  function automatic logic [31:0] sel_addr(input logic [1:0] r);
    logic [31:0] a;
    a = $urandom;
    a[31:24] = 8'hC0;
    a[3:2] = r;
    return a;
  endfunction

  function automatic logic [31:0] unsel_addr(input logic [1:0] r);
    logic [31:0] a;
    a = $urandom;
    if (a[31:24] == 8'hC0) a[31:24] = 8'hC1;
    a[3:2] = r;
    return a;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    RESET = 1'b1; tick(2); RESET = 1'b0;
    n_cmp++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %h expected 00", leds); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    io_read(A_STAT, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
    io_read(A_TIMER, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_timer0: got %h expected 0", d); end
    tick(5);
    io_read(A_TIMER, d);
    n_cmp++; if (d !== 32'd5) begin n_fail++; $display("FAIL reset_timer5: got %h expected 5", d); end
  endtask

  task automatic test_led_decode();
    logic [31:0] d;
    io_write(A_LED, 32'h0000_00A5);
    n_cmp++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_write: got %h expected a5", leds); end
    io_read(A_LED, d);
    n_cmp++; if (d !== 32'hA5) begin n_fail++; $display("FAIL led_read: got %h expected a5", d); end
    io_write(32'h8000_0000, 32'hFF);
    n_cmp++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_unsel_write: got %h expected a5", leds); end
    io_read(32'h8000_0000, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL led_unsel_read: got %h expected 0", d); end
    io_read(32'h8000_000C, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL timer_unsel_read: got %h expected 0", d); end
    // Simultaneous read and write: old value now, new value after the edge.
    IO_A = A_LED; IO_write = 32'h3C; IOWriteS = 1'b1; IOReadS = 2'b10;
    #1;
    n_cmp++; if (IO_dout !== 32'hA5) begin n_fail++; $display("FAIL led_rw_same: got %h expected a5", IO_dout); end
    @(posedge CLK); #1;
    IOWriteS = 1'b0; IOReadS = 2'b00;
    io_read(A_LED, d);
    n_cmp++; if (d !== 32'h3C) begin n_fail++; $display("FAIL led_rw_after: got %h expected 3c", d); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] d;
    io_write(A_TIMER, 32'hFFFF_FFFE);
    tick(1);
    io_read(A_TIMER, d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_wrap0: got %h expected ffffffff", d); end
    tick(1);
    io_read(A_TIMER, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL timer_wrap1: got %h expected 0", d); end
    tick(1);
    io_read(A_TIMER, d);
    n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL timer_wrap2: got %h expected 1", d); end
  endtask

  task automatic test_uart_frame();
    logic [31:0] d;
    logic [7:0]  b;
    logic        exp_bit;
    b = 8'h55;
    rx_q.delete();
    io_write(A_DATA, {24'h0, b});
    io_read(A_STAT, d);
    n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL frame_busy_rise: got %h expected 1", d); end
    tick(1);
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL frame_early_start: got %b expected 1", uart_tx); end
    tick(1);
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c < CPB) exp_bit = 1'b0;
      else if (c >= 9 * CPB) exp_bit = 1'b1;
      else exp_bit = b[c / CPB - 1];
      n_cmp++;
      if (uart_tx !== exp_bit) begin n_fail++; $display("FAIL frame_bit c=%0d: got %b expected %b", c, uart_tx, exp_bit); end
      if (c < 10 * CPB - 1) begin
        io_read(A_STAT, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL frame_busy c=%0d: got %h expected 1", c, d); end
      end
      tick(1);
    end
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL frame_end_idle: got %b expected 1", uart_tx); end
    io_read(A_STAT, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL frame_busy_fall: got %h expected 0", d); end
    n_cmp++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL frame_rx_count: got %0d expected 1", rx_q.size()); end
    else begin
      n_cmp++; if (rx_q[0] !== b) begin n_fail++; $display("FAIL frame_rx_byte: got %h expected %h", rx_q[0], b); end
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    rx_q.delete();
    for (int i = 1; i <= 6; i++) io_write(A_DATA, 32'(i));
    io_read(A_STAT, d);
    n_cmp++; if (d !== 32'h7) begin n_fail++; $display("FAIL ovf_status: got %h expected 7", d); end
    io_write(A_STAT, 32'hFFFF_FFFB);
    io_read(A_STAT, d);
    n_cmp++; if (d[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_keep: got %b expected 1", d[2]); end
    io_write(A_STAT, 32'h4);
    io_read(A_STAT, d);
    n_cmp++; if (d[2] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", d[2]); end
    for (int i = 0; i < 400 && rx_q.size() < 5; i++) tick(1);
    tick(60);
    n_cmp++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_rx_count: got %0d expected 5", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 5; i++) begin
      n_cmp++;
      if (rx_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL ovf_rx_byte%0d: got %h expected %h", i, rx_q[i], 8'(i + 1)); end
    end
    io_read(A_STAT, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_drained: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  exp_q[$];
    int          k;
    for (int r = 0; r < 3; r++) begin
      rx_q.delete();
      exp_q.delete();
      k = (r == 0) ? 5 : $urandom_range(1, 5);
      for (int i = 0; i < k; i++) begin
        exp_q.push_back(8'($urandom));
        io_write(sel_addr(2'd1), {24'($urandom), exp_q[i]});
      end
      for (int i = 0; i < k * 10 * CPB + 100 && rx_q.size() < k; i++) tick(1);
      tick(4);
      n_cmp++; if (rx_q.size() != k) begin n_fail++; $display("FAIL b2b_count r=%0d: got %0d expected %0d", r, rx_q.size(), k); end
      for (int i = 0; i < rx_q.size() && i < k; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte r=%0d i=%0d: got %h expected %h", r, i, rx_q[i], exp_q[i]); end
      end
      io_read(A_STAT, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_status r=%0d: got %h expected 0", r, d); end
    end
    n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL framing: got %0d errors expected 0", frame_err); end
  endtask

  task automatic test_random_regs();
    logic [31:0] d, v, exp;
    int          op;
    v = $urandom;
    io_write(sel_addr(2'd3), v);
    m_timer_base = v; m_timer_cyc = cyc;
    m_leds = leds;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: begin v = $urandom; io_write(sel_addr(2'd0), v); m_leds = v[7:0]; end
        1: begin
          io_read(sel_addr(2'd0), d); exp = {24'h0, m_leds};
          n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL rnd_led_read: got %h expected %h", d, exp); end
        end
        2: begin v = $urandom; io_write(sel_addr(2'd3), v); m_timer_base = v; m_timer_cyc = cyc; end
        3: begin
          io_read(sel_addr(2'd3), d); exp = m_timer_base + (cyc - m_timer_cyc);
          n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL rnd_timer_read: got %h expected %h", d, exp); end
        end
        4: begin
          v = $urandom; io_write(unsel_addr(2'($urandom_range(0, 3))), v);
          n_cmp++; if (leds !== m_leds) begin n_fail++; $display("FAIL rnd_unsel_write: got %h expected %h", leds, m_leds); end
        end
        5: begin
          io_read(unsel_addr(2'($urandom_range(0, 3))), d);
          n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rnd_unsel_read: got %h expected 0", d); end
        end
        6: begin
          io_read(sel_addr(2'd2), d);
          n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rnd_status_read: got %h expected 0", d); end
        end
        default: begin
          io_read(sel_addr(2'd1), d);
          n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rnd_data_read: got %h expected 0", d); end
        end
      endcase
      tick($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic        quiet;
    io_write(A_LED, 32'h5A);
    rx_q.delete();
    io_write(A_DATA, 32'hA6);
    io_write(A_DATA, 32'h3C);
    io_write(A_DATA, 32'hF0);
    n_cmp++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_start: got %b expected 0", uart_tx); end
    tick(CPB + 3 * CPB + 1);
    RESET = 1'b1; tick(1); RESET = 1'b0;
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx: got %b expected 1", uart_tx); end
    n_cmp++; if (leds !== 8'h00) begin n_fail++; $display("FAIL mid_leds: got %h expected 00", leds); end
    io_read(A_STAT, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_status: got %h expected 0", d); end
    io_read(A_TIMER, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_timer: got %h expected 0", d); end
    quiet = 1'b1;
    for (int i = 0; i < 30 * CPB; i++) begin
      if (uart_tx !== 1'b1) quiet = 1'b0;
      tick(1);
    end
    n_cmp++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_quiet: got %b expected 1", quiet); end
    n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_rx: got %0d frames expected 0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_led_decode();
    test_timer_wrap();
    test_uart_frame();
    test_fifo_overflow();
    test_back_to_back();
    test_random_regs();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_periph_responder.md
# io_periph_responder

Memory-mapped IO responder on the CPU's IO bus: the peripheral end of the `IO_A` / `IOReadS` / `IOWriteS` / `IO_write` / `IO_dout` interface the CPU drives for addresses with `IO_A[31:24] == 8'hC0`. The block holds these resources:
- an LED register;
- a free-running 32-bit cycle timer;
- a UART transmitter (8N1) fed by a small byte FIFO.

It sits at SoC top level beside the CPU; `IO_dout` feeds the CPU's read-data mux.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries. Power of two, ≥ 2.
- `LED_W`, default 8: LED register width, ≤ 32.

Ports:
- `CLK`  in  1: single clock; all state on its rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `IO_A`  in  32: byte address from the CPU.
- `IOReadS`  in  2: read strobe; any nonzero value means read.
- `IOWriteS`  in  1: write strobe.
- `IO_write`  in  32: write data.
- `IO_dout`  out  32: read data.
- `uart_tx`  out  1: serial output; idle high.
- `leds`  out  `LED_W`: LED register contents.

## Operation
Decode:
- An access is selected only when `IO_A[31:24] == 8'hC0`.
- The register is chosen by `IO_A[3:2]`. Other address bits are ignored.
- Unselected accesses are ignored, and `IO_dout` is 0 for them.

Register map (byte offsets):
- 0x0: LEDS, RW.
  - Write: `leds <= IO_write[LED_W-1:0]`.
  - Read: zero-extended.
- 0x4: UART_DATA, W.
  - Write: pushes `IO_write[7:0]` into the FIFO if it is not full.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - Reads return 0.
- 0x8: UART_STATUS, RW.
  - Read fields: bit0 `busy` (FIFO non-empty or shifter active), bit1 `full`, bit2 `ovf`; all other bits 0.
  - Write with `IO_write[2]=1` clears `ovf`. Other bits are ignored.
- 0xC: TIMER, RW.
  - Read: current count.
  - Write: loads `IO_write`.
  - Increments by 1 every cycle, wrapping 0xFFFFFFFF→0. A load takes priority over the increment that cycle.

Reads have no side effects. Simultaneous read and write to the same address:
- The read returns the pre-edge value.
- The write takes effect at the edge.

FIFO:
- Circular buffer with `$clog2(FIFO_DEPTH)+1`-bit count.
- `full` is evaluated on pre-edge state: a push while full is dropped even if a pop happens that same edge.
- A push into an empty FIFO while the shifter is idle is popped no earlier than the next edge.

UART transmitter FSM, with a bit counter (0..7) and a baud counter (0..`CLKS_PER_BIT`-1):
- IDLE:
  - `uart_tx`=1.
  - If the FIFO is non-empty, pop into the shift register and go to START.
- START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `uart_tx` = shift register bit, LSB first.
  - Each bit is held `CLKS_PER_BIT` cycles.
  - After bit 7, go to STOP.
- STOP:
  - `uart_tx`=1 for `CLKS_PER_BIT` cycles.
  - Then, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no extra idle cycle); else go to IDLE.

`uart_tx` is registered.

## Timing
Reset values (the first edge with `RESET`=1 forces all of the following):
- `leds`=0, timer=0, FIFO empty, `ovf`=0, FSM=IDLE, `uart_tx`=1.
- `IO_dout` is combinational and therefore reflects these values.

Reset mid-frame:
- `uart_tx` returns to 1 at the reset edge.
- Queued bytes are discarded.

`IO_dout` timing:
- Combinational from `IO_A`/`IOReadS` and registered state.
- Valid in the same cycle as the strobe.
- 0 whenever `IOReadS`=0 or the access is unselected.

Writes commit on the edge where `IOWriteS`=1; visible to reads the following cycle.

Timer read value: one cycle after the load edge, a read returns load value + 1.

UART latency (write to shift-out):
- Write edge N into an empty FIFO with FSM in IDLE.
- Pop at edge N+1.
- Start bit appears on `uart_tx` after edge N+2.
- A frame occupies exactly 10×`CLKS_PER_BIT` cycles.

`busy` timing:
- Goes 1 the cycle after the write edge.
- Returns 0 the cycle after the last STOP cycle, provided the FIFO is empty.

## Test plan
- Reset then idle: assert `RESET` 2 cycles → `leds`=0, `uart_tx`=1, STATUS read = 0x0, TIMER reads 0 one cycle after release and 5 after 5 more cycles.
- LED/decode: write 0xC0000000←0xA5 → `leds`=0xA5 and readback 0xA5; write 0x80000000←0xFF → `leds` unchanged and `IO_dout`=0.
- Timer load/wrap: write TIMER←0xFFFFFFFE → reads 0xFFFFFFFF, then 0x0, then 0x1 on consecutive cycles.
- UART frame (`CLKS_PER_BIT`=4): write UART_DATA←0x55 → `uart_tx` shows 0,1,0,1,0,1,0,1,0,1 at 4 cycles/bit; `busy`=1 throughout the frame, 0 after.
- FIFO overflow (`FIFO_DEPTH`=4, `CLKS_PER_BIT`=4): 6 back-to-back writes 0x01..0x06 → frames carry 0x01..0x05 (one byte popped into the shifter, 4 queued), 0x06 dropped, STATUS bit2=1; write STATUS←0x4 → bit2=0.
- Reset mid-frame: assert `RESET` during DATA bit 3 → `uart_tx`=1 next cycle, FIFO empty, no further frames.
